event_logger: RTL and testbench
===============================

# event_logger

Parametrised change/edge event recorder for simulation-visible and on-chip debug use. Samples NCH channels of W bits each every clock, detects per-channel events (any value change, or rising edge of bit 0), and pushes one record per event cycle into an internal FIFO. Each record holds a timestamp, the fired-channel mask and a full snapshot of all channels. Sits beside the logic under observation; a consumer drains records over a valid/ready port.

## Interface
- NCH, 3: number of observed channels (1..32)
- W, 2: bits per channel (1..32)
- DEPTH, 8: FIFO entries, power of two, >= 2
- TSW, 16: timestamp width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ch_data  in  NCH*W  channel values, channel i = ch_data[i*W +: W]
- ev_mode  in  NCH  per channel: 0 = any change, 1 = rising edge of bit 0
- ev_en  in  NCH  per-channel event enable
- rd_valid  out  1  record available
- rd_ready  in  1  consumer accepts record
- rd_ts  out  TSW  record timestamp
- rd_mask  out  NCH  channels that fired
- rd_snap  out  NCH*W  ch_data at the event edge
- rd_ovf  out  1  one or more records dropped before this one
- level  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- prev register holds ch_data from previous edge; armed flag clear after reset.
- Fire for channel i: ev_en[i] & armed & (ev_mode[i] ? (!prev_i[0] & cur_i[0]) : (cur_i != prev_i)).
- Any fire -> one record {ts, mask, ch_data, ovf_pend} written that edge; simultaneous fires share one record, no arbitration.
- Timestamp counter: 0 after reset, +1 every cycle, wraps modulo 2^TSW; record takes pre-increment value.
- FIFO full at write: record dropped, ovf_pend set; next accepted record carries rd_ovf=1, then ovf_pend clears.
- Full with pop same cycle: pop frees slot, write accepted, ovf_pend unchanged.
- Pop: rd_valid & rd_ready. Push and pop same cycle: level unchanged.
- First-word-fall-through: rd_* show head entry while rd_valid.
- Reset mid-operation: FIFO emptied, ovf_pend, armed, counter cleared; prev loads ch_data on first edge after reset.

## Timing
- Reset values: rd_valid 0, rd_ts 0, rd_mask 0, rd_snap 0, rd_ovf 0, level 0.
- First edge after reset only arms; events possible from second edge.
- Event latency: ch_data change sampled at edge n -> rd_valid high after edge n (FIFO was empty), level increments at edge n.
- rd_* stable while rd_valid & !rd_ready.
- Wrapping pointers, extra MSB distinguishes full from empty.

## Configuration
- EVENT_LOGGER_TIMESTAMP_EN defined: TSW-bit counter built, stored per record, driven on rd_ts.
- Undefined: counter and ts storage removed, rd_ts tied 0; port list unchanged.

## Structure
- Package evlog_pkg: mode encodings (EV_MODE_CHANGE=0, EV_MODE_RISE=1), record-width function of NCH, W, TSW, clog2 helper.
- One sub-module: evlog_fifo (parametrised width/depth, FWFT, push/pop/full/empty/level); detection, timestamp and overflow logic in event_logger.

## Test plan
- NCH=3, W=2, ev_en=7, ev_mode=3'b001; ch0,1,2 = 0, then ch0=1 at cycle 5 -> one record mask=3'b001, snap={0,0,1}, ts=5.
- Same config, ch1 and ch2 change in same cycle 0->3 -> single record mask=3'b110.
- ev_mode[0]=1: ch0 0->2 (bit0 stays 0) -> no record; 2->3 -> record mask=3'b001.
- DEPTH=4, rd_ready=0, 6 event cycles -> level=4, 2 dropped; drain -> 4 records rd_ovf=0; next event record rd_ovf=1, following rd_ovf=0.
- FIFO full, rd_ready=1 and event same cycle -> level stays 4, no drop, rd_ovf never set.
- rst asserted with 3 entries queued -> next cycle rd_valid=0, level=0; change on first post-reset edge -> no record; ts restarts at 0.

Source files
------------

// File: rtl/evlog_pkg.sv
// evlog_pkg: shared definitions for the event logger.
//   EV_MODE_CHANGE / EV_MODE_RISE : per-channel detection mode encodings
//   clog2()                       : ceiling log2, used for pointer and level widths
//   rec_width()                   : bits in one stored record {ts, mask, snapshot, ovf}
package evlog_pkg;

  localparam logic EV_MODE_CHANGE = 1'b0;
  localparam logic EV_MODE_RISE   = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // tsw is 0 when the timestamp is not stored.
  function automatic int rec_width(input int nch, input int w, input int tsw);
    return tsw + nch + (nch * w) + 1;
  endfunction

endpackage

// File: rtl/evlog_fifo.sv
// evlog_fifo: first-word-fall-through FIFO holding event records.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data this edge (ignored when full unless popping too)
//   push_data  : record to write
//   pop        : remove head entry this edge (ignored when empty)
//   pop_data   : head entry, zero while empty
//   full/empty : occupancy flags
//   level      : number of stored entries
// Pointers carry one extra MSB so full and empty are distinguishable.
module evlog_fifo
  import evlog_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push = push & (~full | do_pop);

  // Zero while empty so the record outputs read as zero out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/event_logger.sv
// event_logger: per-channel change / rising-edge event recorder with a record FIFO.
//   clk, rst  : clock, synchronous active-high reset
//   ch_data   : NCH channels of W bits, channel i = ch_data[i*W +: W]
//   ev_mode   : per channel, 0 = any value change, 1 = rising edge of bit 0
//   ev_en     : per-channel event enable
//   rd_valid / rd_ready : record read port
//   rd_ts     : record timestamp (0 when timestamps are compiled out)
//   rd_mask   : channels that fired in the recorded cycle
//   rd_snap   : ch_data captured at the event edge
//   rd_ovf    : one or more records were dropped before this one
//   level     : FIFO occupancy
// Build option: define EVENT_LOGGER_TIMESTAMP_EN to build the timestamp counter
// and store it per record; otherwise rd_ts is tied to zero.
//
// Read handshake: a record transfers on any edge where rd_valid & rd_ready are
// both high; rd_valid never depends on rd_ready, and while rd_valid is high
// without rd_ready the rd_* outputs hold the same record.
module event_logger
  import evlog_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int W     = 2,
  parameter int DEPTH = 8,
  parameter int TSW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH*W-1:0]        ch_data,
  input  logic [NCH-1:0]          ev_mode,
  input  logic [NCH-1:0]          ev_en,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [TSW-1:0]          rd_ts,
  output logic [NCH-1:0]          rd_mask,
  output logic [NCH*W-1:0]        rd_snap,
  output logic                    rd_ovf,
  output logic [clog2(DEPTH):0]   level
);

`ifdef EVENT_LOGGER_TIMESTAMP_EN
  localparam int TS_STORE = TSW;
`else
  localparam int TS_STORE = 0;
`endif
  localparam int REC_W = rec_width(NCH, W, TS_STORE);

  logic [NCH*W-1:0] prev;
  logic             armed;
  logic             ovf_pend;
  logic [NCH-1:0]   fire_mask;
  logic             any_fire;
  logic             pop_fire;
  logic             push_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] pop_rec;

  // Per-channel event detection against the value seen on the previous edge.
  always_comb begin
    fire_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [W-1:0] cur;
      logic [W-1:0] prv;
      logic         hit;
      cur = ch_data[i*W +: W];
      prv = prev[i*W +: W];
      if (ev_mode[i] == EV_MODE_RISE) hit = ~prv[0] & cur[0];
      else                            hit = (cur != prv);
      fire_mask[i] = ev_en[i] & armed & hit;
    end
  end

  assign any_fire = |fire_mask;
  assign pop_fire = rd_valid & rd_ready;
  assign push_ok  = any_fire & (~fifo_full | pop_fire);

  // prev is loaded every edge, including during reset; armed keeps the first
  // post-reset comparison from firing against a stale value.
  always_ff @(posedge clk) begin
    prev <= ch_data;
    if (rst) begin
      armed    <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (any_fire && !push_ok) ovf_pend <= 1'b1;
      else if (push_ok)         ovf_pend <= 1'b0;
    end
  end

`ifdef EVENT_LOGGER_TIMESTAMP_EN
  logic [TSW-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + {{(TSW-1){1'b0}}, 1'b1};
  end

  // Record carries the pre-increment count of the event edge.
  assign push_rec = {ts_cnt, fire_mask, ch_data, ovf_pend};
  assign rd_ts    = pop_rec[REC_W-1 -: TSW];
`else
  assign push_rec = {fire_mask, ch_data, ovf_pend};
  assign rd_ts    = {TSW{1'b0}};
`endif

  assign rd_mask  = pop_rec[1 + NCH*W +: NCH];
  assign rd_snap  = pop_rec[1 +: NCH*W];
  assign rd_ovf   = pop_rec[0];
  assign rd_valid = ~fifo_empty;

  evlog_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (push_rec),
    .pop       (pop_fire),
    .pop_data  (pop_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule

// File: tb/tb_event_logger.sv
// tb_event_logger: directed bench for event_logger (NCH=3, W=2, DEPTH=4, TSW=16).
// Expected records are queued in exp_q when the stimulus creates an event and
// compared against the read port when drained.
module tb_event_logger;

  localparam int NCH   = 3;
  localparam int W     = 2;
  localparam int DEPTH = 4;
  localparam int TSW   = 16;
  localparam int RW    = TSW + NCH + NCH*W + 1;

`ifdef EVENT_LOGGER_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ev_mode;
  logic [NCH-1:0]   ev_en;
  logic             rd_valid;
  logic             rd_ready;
  logic [TSW-1:0]   rd_ts;
  logic [NCH-1:0]   rd_mask;
  logic [NCH*W-1:0] rd_snap;
  logic             rd_ovf;
  logic [2:0]       level;

  int n_checks = 0;
  int n_pass   = 0;
  int ts_now   = 0;
  logic [RW-1:0] exp_q[$];

  event_logger #(
    .NCH(NCH), .W(W), .DEPTH(DEPTH), .TSW(TSW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_data  (ch_data),
    .ev_mode  (ev_mode),
    .ev_en    (ev_en),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_ts    (rd_ts),
    .rd_mask  (rd_mask),
    .rd_snap  (rd_snap),
    .rd_ovf   (rd_ovf),
    .level    (level)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // One clock edge; ts_now tracks the timestamp the next edge will record.
  task automatic step();
    @(posedge clk);
    if (rst) ts_now = 0;
    else     ts_now++;
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Queue the record the coming edge should write.
  task automatic expect_rec(input logic [NCH-1:0] mask, input logic ovf);
    logic [TSW-1:0] ts;
    ts = TS_ON ? TSW'(ts_now) : '0;
    exp_q.push_back({ts, mask, ch_data, ovf});
  endtask

  task automatic check_head(input string tag);
    logic [RW-1:0] e;
    if (exp_q.size() != 0) e = exp_q[0];
    else                   e = '0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check({tag, "_ts"},    64'(rd_ts),    64'(e[RW-1 -: TSW]));
    check({tag, "_mask"},  64'(rd_mask),  64'(e[1 + NCH*W +: NCH]));
    check({tag, "_snap"},  64'(rd_snap),  64'(e[1 +: NCH*W]));
    check({tag, "_ovf"},   64'(rd_ovf),   64'(e[0]));
  endtask

  task automatic drain_one(input string tag);
    check_head(tag);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic flip_ch(input int idx);
    ch_data[idx*W +: W] = ~ch_data[idx*W +: W];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    ch_data  = '0;
    ev_en    = 3'b111;
    ev_mode  = 3'b001;
    rd_ready = 1'b0;
    repeat (3) step();

    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_ts",    64'(rd_ts),    64'd0);
    check("rst_mask",  64'(rd_mask),  64'd0);
    check("rst_snap",  64'(rd_snap),  64'd0);
    check("rst_ovf",   64'(rd_ovf),   64'd0);
    check("rst_level", 64'(level),    64'd0);

    // Single rising-edge event on ch0 at post-reset edge 5.
    rst = 1'b0;
    repeat (5) step();
    check("idle_level", 64'(level), 64'd0);
    ch_data = 6'b00_00_01;
    expect_rec(3'b001, 1'b0);
    step();
    check("t1_level", 64'(level), 64'd1);
    check("t1_ts5",   64'(rd_ts), TS_ON ? 64'd5 : 64'd0);
    drain_one("t1");
    check("t1_empty", 64'(rd_valid), 64'd0);

    // ch1 and ch2 change together: one record.
    ch_data = 6'b11_11_01;
    expect_rec(3'b110, 1'b0);
    step();
    check("t2_level", 64'(level), 64'd1);
    drain_one("t2");

    // Rise mode on ch0: 1->0 and 0->2 do not fire, 2->3 does.
    ch_data = 6'b11_11_00;
    step();
    check("t3_fall_level", 64'(level), 64'd0);
    ch_data = 6'b11_11_10;
    step();
    check("t3_b0low_level", 64'(level), 64'd0);
    ch_data = 6'b11_11_11;
    expect_rec(3'b001, 1'b0);
    step();
    check("t3_level", 64'(level), 64'd1);
    drain_one("t3");

    // Overflow: 6 event cycles into a 4-deep FIFO, 2 dropped.
    for (int i = 0; i < 6; i++) begin
      flip_ch(1);
      if (i < 4) expect_rec(3'b010, 1'b0);
      step();
    end
    check("t4_full_level", 64'(level), 64'd4);
    for (int i = 0; i < 4; i++) drain_one("t4_drain");
    check("t4_drained_level", 64'(level), 64'd0);
    flip_ch(2);
    expect_rec(3'b100, 1'b1);
    step();
    drain_one("t4_ovf_rec");
    flip_ch(2);
    expect_rec(3'b100, 1'b0);
    step();
    drain_one("t4_after_ovf");

    // Full FIFO, pop and event in the same cycle: no drop.
    for (int i = 0; i < 4; i++) begin
      flip_ch(1);
      expect_rec(3'b010, 1'b0);
      step();
    end
    check("t5_full_level", 64'(level), 64'd4);
    check_head("t5_head");
    rd_ready = 1'b1;
    flip_ch(1);
    expect_rec(3'b010, 1'b0);
    step();
    rd_ready = 1'b0;
    void'(exp_q.pop_front());
    check("t5_level_kept", 64'(level), 64'd4);
    for (int i = 0; i < 4; i++) drain_one("t5_drain");
    check("t5_drained_level", 64'(level), 64'd0);

    // Reset with 3 entries queued.
    for (int i = 0; i < 3; i++) begin
      flip_ch(2);
      expect_rec(3'b100, 1'b0);
      step();
    end
    check("t6_pre_level", 64'(level), 64'd3);
    rst = 1'b1;
    step();
    exp_q.delete();
    check("t6_rst_valid", 64'(rd_valid), 64'd0);
    check("t6_rst_level", 64'(level),    64'd0);
    check("t6_rst_mask",  64'(rd_mask),  64'd0);
    rst = 1'b0;
    flip_ch(1);
    step();
    check("t6_arm_level", 64'(level),    64'd0);
    check("t6_arm_valid", 64'(rd_valid), 64'd0);
    flip_ch(1);
    expect_rec(3'b010, 1'b0);
    step();
    check("t6_ts1", 64'(rd_ts), TS_ON ? 64'd1 : 64'd0);
    drain_one("t6");
    check("t6_end_level", 64'(level), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
